axi_ram_slave: RTL

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a 2^RAM_AW x 32-bit RAM. Read and write paths are independent FSMs with one transaction each.
// Optional macro AXI_RAM_RLAT_EN holds each read in R_WAIT for 4 cycles before the first beat.
module axi_ram_slave #(
  parameter int RAM_AW = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic [1:0]  axi_awlock,
  input  logic [3:0]  axi_awcache,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [3:0]  axi_wid,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic [1:0]  axi_arlock,
  input  logic [3:0]  axi_arcache,
  input  logic [2:0]  axi_arprot,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready
);
  localparam int DEPTH = 1 << RAM_AW;

`ifdef AXI_RAM_RLAT_EN
  localparam logic RLAT = 1'b1;
`else
  localparam logic RLAT = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0]       mem [DEPTH];
  rstate_t           rstate, rstate_nx;
  wstate_t           wstate, wstate_nx;
  logic [RAM_AW-1:0] rptr, wptr;
  logic [3:0]        rlen, rbeat;
  logic [3:0]        rid_cap, bid_cap;
  logic [1:0]        rwait;
  logic              ar_hs, r_hs, aw_hs, w_hs;

  // Attribute fields the RAM has no use for (size, burst type, cache, ...).
  logic unused;
  assign unused = ^{axi_awaddr[31:RAM_AW+2], axi_awaddr[1:0], axi_awlen[7:4], axi_awsize,
                    axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_wid,
                    axi_araddr[31:RAM_AW+2], axi_araddr[1:0], axi_arlen[7:4], axi_arsize,
                    axi_arburst, axi_arlock, axi_arcache, axi_arprot};

  assign ar_hs = axi_arvalid && axi_arready;
  assign r_hs  = axi_rvalid && axi_rready;
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;

  assign axi_arready = (rstate == R_IDLE);
  assign axi_rvalid  = (rstate == R_DATA);
  assign axi_rdata   = axi_rvalid ? mem[rptr] : '0;
  assign axi_rlast   = axi_rvalid && (rbeat == rlen);
  assign axi_rid     = rid_cap;
  assign axi_rresp   = 2'b00;

  assign axi_awready = (wstate == W_IDLE);
  assign axi_wready  = (wstate == W_DATA);
  assign axi_bvalid  = (wstate == W_RESP);
  assign axi_bid     = bid_cap;
  assign axi_bresp   = 2'b00;

  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE:  if (axi_arvalid) rstate_nx = RLAT ? R_WAIT : R_DATA;
      R_WAIT:  if (rwait == 2'd3) rstate_nx = R_DATA;
      R_DATA:  if (axi_rready && axi_rlast) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate  <= R_IDLE;
      rptr    <= '0;
      rlen    <= '0;
      rbeat   <= '0;
      rid_cap <= '0;
      rwait   <= '0;
    end else begin
      rstate <= rstate_nx;
      if (ar_hs) begin
        rid_cap <= axi_arid;
        rptr    <= axi_araddr[RAM_AW+1:2];
        rlen    <= axi_arlen[3:0];
        rbeat   <= '0;
        rwait   <= '0;
      end
      if (rstate == R_WAIT) rwait <= rwait + 2'd1;
      if (r_hs) begin
        rptr  <= rptr + RAM_AW'(1);
        rbeat <= rbeat + 4'd1;
      end
    end
  end

  // Write burst ends on wlast alone; awlen is not tracked.
  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_IDLE:  if (axi_awvalid) wstate_nx = W_DATA;
      W_DATA:  if (axi_wvalid && axi_wlast) wstate_nx = W_RESP;
      W_RESP:  if (axi_bready) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate  <= W_IDLE;
      wptr    <= '0;
      bid_cap <= '0;
    end else begin
      wstate <= wstate_nx;
      if (aw_hs) begin
        bid_cap <= axi_awid;
        wptr    <= axi_awaddr[RAM_AW+1:2];
      end
      if (w_hs) wptr <= wptr + RAM_AW'(1);
    end
  end

  // RAM is never cleared by reset; reads are combinational so a same-cycle write shows up next cycle.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++)
        if (axi_wstrb[i]) mem[wptr][8*i +: 8] <= axi_wdata[8*i +: 8];
    end
  end
endmodule
